// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one memory-stage operation at a time, checks legality and
// alignment, drives a doubleword-wide request until acknowledged or timed out, and extends load data.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic        load_valid,
    output logic [63:0] load_data,
    output logic        align_fault,
    output logic        bus_fault,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [15:0] wait_cnt;
    logic [63:0] addr_q, wdata_q, load_q;
    logic [2:0]  funct3_q;
    logic [7:0]  be_q;
    logic        we_q, flush_seen, bus_flag, align_flag;

    logic        accept, illegal, misaligned, timeout_hit;
    logic [7:0]  be_size;
    logic [63:0] rdata_shift, load_ext;

    always_comb begin
        accept      = op_valid & (MemRead | MemWrite) & ~flush;
        illegal     = (MemRead & MemWrite) | (MemWrite & funct3[2]) | (funct3 == 3'b111);
        misaligned  = 1'b0;
        be_size     = 8'h01;
        unique case (funct3[1:0])
            2'b00:   begin misaligned = 1'b0;              be_size = 8'h01; end
            2'b01:   begin misaligned = addr[0];           be_size = 8'h03; end
            2'b10:   begin misaligned = |addr[1:0];        be_size = 8'h0F; end
            default: begin misaligned = |addr[2:0];        be_size = 8'hFF; end
        endcase
        timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    end

    // Load result: bring the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        rdata_shift = mem_rdata >> {addr_q[2:0], 3'b000};
        load_ext    = rdata_shift;
        unique case (funct3_q)
            3'b000:  load_ext = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
            3'b001:  load_ext = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b010:  load_ext = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
            3'b100:  load_ext = {56'd0, rdata_shift[7:0]};
            3'b101:  load_ext = {48'd0, rdata_shift[15:0]};
            3'b110:  load_ext = {32'd0, rdata_shift[31:0]};
            default: load_ext = rdata_shift;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = (illegal || misaligned) ? S_FAULT : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem_ack)          state_next = S_DONE;
                else if (timeout_hit) state_next = S_FAULT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= '0;
            funct3_q   <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            flush_seen <= 1'b0;
            bus_flag   <= 1'b0;
            align_flag <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && accept) begin
                bus_flag   <= illegal;
                align_flag <= ~illegal & misaligned;
                flush_seen <= 1'b0;
                wait_cnt   <= '0;
                // Only legal accesses overwrite the bus-facing registers.
                if (!illegal && !misaligned) begin
                    addr_q   <= addr;
                    funct3_q <= funct3;
                    we_q     <= MemWrite;
                    be_q     <= be_size << addr[2:0];
                    wdata_q  <= wdata << {addr[2:0], 3'b000};
                end
            end
            if (state == S_REQ) begin
                if (flush) flush_seen <= 1'b1;
                if (mem_ack) begin
                    if (!we_q) load_q <= load_ext;
                end else if (timeout_hit) begin
                    bus_flag   <= 1'b1;
                    align_flag <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
            end
        end
    end

    assign mem_req     = (state == S_REQ);
    assign mem_we      = mem_req & we_q;
    assign mem_be      = mem_req ? be_q : 8'h00;
    assign mem_addr    = {addr_q[63:3], 3'b000};
    assign mem_wdata   = wdata_q;
    assign load_data   = load_q;
    assign load_valid  = (state == S_DONE) & ~we_q & ~flush_seen & ~flush;
    assign align_fault = (state == S_FAULT) & align_flag;
    assign bus_fault   = (state == S_FAULT) & bus_flag;
    assign fsm_state   = state;

endmodule
